dict_codec_engine: RTL and testbench



---
 rtl/dict_codec_pkg.sv | 30 +++
 rtl/dict_codec_engine_if.sv | 34 +++
 rtl/dict_codec_store.sv | 74 +++++++
 rtl/dict_codec_engine.sv | 184 ++++++++++++++++++
 tb/tb_dict_codec_engine.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dict_codec_pkg.sv
// Shared types for the dictionary codec engine.
//   cmd_e   : host command encoding
//   rsp_e   : response encoding
//   state_e : engine control states
//   STATS_W : width of the optional statistics counters
package dict_codec_pkg;

  typedef enum logic [1:0] {
    CMD_CLEAR      = 2'b00,
    CMD_COMPRESS   = 2'b01,
    CMD_DECOMPRESS = 2'b10,
    CMD_ILLEGAL    = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    RSP_CLEAR_OK  = 2'b00,
    RSP_COMP_OK   = 2'b01,
    RSP_DECOMP_OK = 2'b10,
    RSP_ERROR     = 2'b11
  } rsp_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SEARCH = 2'b01,
    RESP   = 2'b10
  } state_e;

  localparam int STATS_W = 16;

endpackage

// File: rtl/dict_codec_engine_if.sv
// Command/response bus of the dictionary codec engine.
//   cmd_valid/cmd_ready : command handshake (command, data_in, compressed_in)
//   rsp_valid/rsp_ready : response handshake (response, compressed_out,
//                         decompressed_out, hit)
// master = host/consumer side, slave = engine side.
interface dict_codec_engine_if #(
  parameter int DATA_W = 80,
  parameter int IDX_W  = 8
) ();
  import dict_codec_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  cmd_e              command;
  logic [DATA_W-1:0] data_in;
  logic [IDX_W-1:0]  compressed_in;
  logic              rsp_valid;
  logic              rsp_ready;
  rsp_e              response;
  logic [IDX_W-1:0]  compressed_out;
  logic [DATA_W-1:0] decompressed_out;
  logic              hit;

  modport master (
    output cmd_valid, command, data_in, compressed_in, rsp_ready,
    input  cmd_ready, rsp_valid, response, compressed_out, decompressed_out, hit
  );

  modport slave (
    input  cmd_valid, command, data_in, compressed_in, rsp_ready,
    output cmd_ready, rsp_valid, response, compressed_out, decompressed_out, hit
  );

endinterface

// File: rtl/dict_codec_store.sv
// Dictionary storage: DEPTH x DATA_W words with per-entry valid bits and an
// append pointer (fill_count).
//   wr_en/wr_data     : append wr_data at index fill_count
//   clr               : drop all entries
//   base/key          : LANES-wide compare window; match vector and the lowest
//                       matching index (match_idx)
//   rd_idx/rd_data    : combinational random read
//   fill_count        : number of valid entries
module dict_codec_store #(
  parameter int DATA_W = 80,
  parameter int DEPTH  = 255,
  parameter int IDX_W  = 8,
  parameter int LANES  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr,
  input  logic [IDX_W:0]    base,
  input  logic [DATA_W-1:0] key,
  output logic [LANES-1:0]  match,
  output logic [IDX_W-1:0]  match_idx,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic [IDX_W:0]    fill_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [IDX_W:0]    lane_idx;

  // NOTE: the word array has no reset; the valid bits alone decide whether
  // an entry exists, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[fill_count[AW-1:0]] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      valid      <= '0;
      fill_count <= '0;
    end else if (wr_en) begin
      valid[fill_count[AW-1:0]] <= 1'b1;
      fill_count                <= fill_count + 1'b1;
    end
  end

  // Walking lanes from high to low leaves the lowest matching index in
  // match_idx. Lanes past fill_count are masked, so out-of-range reads
  // never contribute.
  // NOTE: every combinational output gets a default first so no path can
  // infer a latch.
  always_comb begin
    match     = '0;
    match_idx = '0;
    lane_idx  = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      lane_idx = base + (IDX_W + 1)'(i);
      if (lane_idx < fill_count && valid[lane_idx[AW-1:0]] &&
          mem[lane_idx[AW-1:0]] == key) begin
        match[i]  = 1'b1;
        match_idx = lane_idx[IDX_W-1:0];
      end
    end
  end

  assign rd_data = mem[rd_idx[AW-1:0]];

endmodule

// File: rtl/dict_codec_engine.sv
// Handshaked dictionary compress/decompress engine.
//   clk, reset : clock and synchronous active-high reset
//   bus        : dict_codec_engine_if.slave command/response bus
//   fill_count : number of valid dictionary entries
// Optional macro DICT_CODEC_STATS_EN adds saturating 16-bit hit_cnt,
// miss_cnt and err_cnt outputs, updated on each response handshake.
module dict_codec_engine
  import dict_codec_pkg::*;
#(
  parameter int DATA_W = 80,
  parameter int DEPTH  = 255,
  parameter int IDX_W  = 8,
  parameter int LANES  = 4
) (
  input  logic                clk,
  input  logic                reset,
  dict_codec_engine_if.slave  bus,
`ifdef DICT_CODEC_STATS_EN
  output logic [STATS_W-1:0]  hit_cnt,
  output logic [STATS_W-1:0]  miss_cnt,
  output logic [STATS_W-1:0]  err_cnt,
`endif
  output logic [IDX_W:0]      fill_count
);

  localparam logic [IDX_W:0]   DEPTH_V = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W:0]   LANES_B = (IDX_W + 1)'(LANES);
  localparam logic [IDX_W+1:0] LANES_W = (IDX_W + 2)'(LANES);

  state_e            state, state_d;
  logic [IDX_W:0]    base_q, base_d;
  logic [DATA_W-1:0] key_q, key_d;
  rsp_e              rsp_q, rsp_d;
  logic [IDX_W-1:0]  cidx_q, cidx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              hit_q, hit_d;
  logic              wr_en, clr;
  logic [DATA_W-1:0] wr_data;
  logic [LANES-1:0]  match;
  logic [IDX_W-1:0]  match_idx;
  logic [DATA_W-1:0] rd_data;
  logic              ready, accept, exhausted;

  // Held low while reset is asserted so no command can slip in.
  assign ready     = (state == IDLE) && !reset;
  assign accept    = bus.cmd_valid && ready;
  assign exhausted = ({1'b0, base_q} + LANES_W) >= {1'b0, fill_count};

  dict_codec_store #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .LANES(LANES)
  ) u_store (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .clr       (clr),
    .base      (base_q),
    .key       (key_q),
    .match     (match),
    .match_idx (match_idx),
    .rd_idx    (bus.compressed_in),
    .rd_data   (rd_data),
    .fill_count(fill_count)
  );

  always_comb begin
    state_d = state;
    base_d  = base_q;
    key_d   = key_q;
    rsp_d   = rsp_q;
    cidx_d  = cidx_q;
    data_d  = data_q;
    hit_d   = hit_q;
    wr_en   = 1'b0;
    wr_data = key_q;
    clr     = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        key_d   = bus.data_in;
        base_d  = '0;
        state_d = RESP;
        case (bus.command)
          CMD_CLEAR: begin
            clr   = 1'b1;
            rsp_d = RSP_CLEAR_OK;
          end
          CMD_COMPRESS: begin
            if (fill_count != '0) begin
              state_d = SEARCH;
            end else begin
              // Empty dictionary: nothing to search, insert at index 0.
              wr_en   = 1'b1;
              wr_data = bus.data_in;
              rsp_d   = RSP_COMP_OK;
              hit_d   = 1'b0;
              cidx_d  = '0;
            end
          end
          CMD_DECOMPRESS: begin
            if ({1'b0, bus.compressed_in} < fill_count) begin
              rsp_d  = RSP_DECOMP_OK;
              data_d = rd_data;
            end else begin
              rsp_d = RSP_ERROR;
            end
          end
          default: rsp_d = RSP_ERROR;
        endcase
      end
      SEARCH: begin
        if (|match) begin
          rsp_d   = RSP_COMP_OK;
          hit_d   = 1'b1;
          cidx_d  = match_idx;
          state_d = RESP;
        end else if (exhausted) begin
          state_d = RESP;
          if (fill_count < DEPTH_V) begin
            wr_en  = 1'b1;
            rsp_d  = RSP_COMP_OK;
            hit_d  = 1'b0;
            cidx_d = fill_count[IDX_W-1:0];
          end else begin
            rsp_d = RSP_ERROR;
          end
        end else begin
          base_d = base_q + LANES_B;
        end
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      base_q <= '0;
      key_q  <= '0;
      rsp_q  <= RSP_CLEAR_OK;
      cidx_q <= '0;
      data_q <= '0;
      hit_q  <= 1'b0;
    end else begin
      state  <= state_d;
      base_q <= base_d;
      key_q  <= key_d;
      rsp_q  <= rsp_d;
      cidx_q <= cidx_d;
      data_q <= data_d;
      hit_q  <= hit_d;
    end
  end

  assign bus.cmd_ready        = ready;
  assign bus.rsp_valid        = (state == RESP);
  assign bus.response         = rsp_q;
  assign bus.compressed_out   = cidx_q;
  assign bus.decompressed_out = data_q;
  assign bus.hit              = hit_q;

`ifdef DICT_CODEC_STATS_EN
  logic rsp_fire;
  assign rsp_fire = (state == RESP) && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (reset || (accept && bus.command == CMD_CLEAR)) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      err_cnt  <= '0;
    end else if (rsp_fire) begin
      if (rsp_q == RSP_COMP_OK && hit_q && hit_cnt != '1)
        hit_cnt <= hit_cnt + 1'b1;
      if (rsp_q == RSP_COMP_OK && !hit_q && miss_cnt != '1)
        miss_cnt <= miss_cnt + 1'b1;
      if (rsp_q == RSP_ERROR && err_cnt != '1)
        err_cnt <= err_cnt + 1'b1;
    end
  end
`else
  // Statistics compiled out: no counters, no extra ports.
`endif

endmodule

// File: tb/tb_dict_codec_engine.sv
// Directed bench for dict_codec_engine: a small instance (DEPTH=4, LANES=1)
// and a large one (DEPTH=255, LANES=4) share one stimulus driver selected by
// 'sel'. A behavioural dictionary model pushes expected responses into a
// scoreboard queue; each response popped is compared with latency included.
module tb_dict_codec_engine;
  import dict_codec_pkg::*;

  typedef struct {
    logic [1:0]  rsp;
    logic [7:0]  cidx;
    logic [79:0] data;
    logic        hit;
    int          lat;
    int          fill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, sel, cmd_valid, rsp_ready;
  cmd_e        command;
  logic [79:0] data_in;
  logic [7:0]  cidx_in;
  logic [3:0]  fill_s;
  logic [8:0]  fill_b;
  logic        o_cmd_ready, o_rsp_valid, o_hit;
  logic [1:0]  o_rsp;
  logic [7:0]  o_cidx;
  logic [79:0] o_data;
  logic [8:0]  o_fill;
  int          n_tests = 0;
  int          n_fail  = 0;

  // Reference model state.
  logic [79:0] m_dict [256];
  int          m_fill, m_depth, m_lanes;
  logic [7:0]  m_cidx;
  logic [79:0] m_data;
  logic        m_hit;
  exp_t        sb[$];

  always #5 clk = ~clk;

  dict_codec_engine_if #(.DATA_W(80), .IDX_W(3)) if_s ();
  dict_codec_engine_if #(.DATA_W(80), .IDX_W(8)) if_b ();

  assign if_s.cmd_valid     = cmd_valid && !sel;
  assign if_s.command       = command;
  assign if_s.data_in       = data_in;
  assign if_s.compressed_in = cidx_in[2:0];
  assign if_s.rsp_ready     = rsp_ready;
  assign if_b.cmd_valid     = cmd_valid && sel;
  assign if_b.command       = command;
  assign if_b.data_in       = data_in;
  assign if_b.compressed_in = cidx_in;
  assign if_b.rsp_ready     = rsp_ready;

  dict_codec_engine #(.DATA_W(80), .DEPTH(4), .IDX_W(3), .LANES(1)) u_small (
    .clk(clk), .reset(reset), .bus(if_s), .fill_count(fill_s)
  );

  dict_codec_engine #(.DATA_W(80), .DEPTH(255), .IDX_W(8), .LANES(4)) u_big (
    .clk(clk), .reset(reset), .bus(if_b), .fill_count(fill_b)
  );

  always_comb begin
    if (sel) begin
      o_cmd_ready = if_b.cmd_ready;
      o_rsp_valid = if_b.rsp_valid;
      o_rsp       = if_b.response;
      o_cidx      = if_b.compressed_out;
      o_data      = if_b.decompressed_out;
      o_hit       = if_b.hit;
      o_fill      = fill_b;
    end else begin
      o_cmd_ready = if_s.cmd_ready;
      o_rsp_valid = if_s.rsp_valid;
      o_rsp       = if_s.response;
      o_cidx      = {5'b0, if_s.compressed_out};
      o_data      = if_s.decompressed_out;
      o_hit       = if_s.hit;
      o_fill      = {5'b0, fill_s};
    end
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int depth, input int lanes);
    m_depth = depth;
    m_lanes = lanes;
    m_fill  = 0;
    m_cidx  = '0;
    m_data  = '0;
    m_hit   = 1'b0;
  endtask

  task automatic model_cmd(input cmd_e cmd, input logic [79:0] d, input int ci);
    exp_t e;
    int   k;
    e.lat = 1;
    case (cmd)
      CMD_CLEAR: begin
        m_fill = 0;
        e.rsp  = 2'b00;
      end
      CMD_COMPRESS: begin
        k = -1;
        for (int i = 0; i < m_fill; i++)
          if (k < 0 && m_dict[i] === d) k = i;
        if (m_fill == 0) begin
          m_dict[0] = d;
          m_fill    = 1;
          m_cidx    = '0;
          m_hit     = 1'b0;
          e.rsp     = 2'b01;
        end else if (k >= 0) begin
          m_cidx = 8'(k);
          m_hit  = 1'b1;
          e.rsp  = 2'b01;
          e.lat  = k / m_lanes + 2;
        end else begin
          e.lat = (m_fill + m_lanes - 1) / m_lanes + 1;
          if (m_fill < m_depth) begin
            m_dict[m_fill] = d;
            m_cidx         = 8'(m_fill);
            m_hit          = 1'b0;
            m_fill++;
            e.rsp = 2'b01;
          end else begin
            e.rsp = 2'b11;
          end
        end
      end
      CMD_DECOMPRESS: begin
        if (ci < m_fill) begin
          m_data = m_dict[ci];
          e.rsp  = 2'b10;
        end else begin
          e.rsp = 2'b11;
        end
      end
      default: e.rsp = 2'b11;
    endcase
    e.cidx = m_cidx;
    e.data = m_data;
    e.hit  = m_hit;
    e.fill = m_fill;
    sb.push_back(e);
  endtask

  task automatic run_cmd(input cmd_e cmd, input logic [79:0] d, input int ci,
                         input int hold, input string tag);
    exp_t e;
    int   lat;
    bit   seen;
    model_cmd(cmd, d, ci);
    @(negedge clk);
    command   = cmd;
    data_in   = d;
    cidx_in   = 8'(ci);
    cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    seen      = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      if (o_cmd_ready) seen = 1'b1;
      else @(negedge clk);
    end
    check({tag, " accept"}, 80'(seen), 80'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat  = 1;
    seen = 1'b0;
    for (int t = 0; t < 400 && !seen; t++) begin
      if (o_rsp_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    e = sb.pop_front();
    check({tag, " rsp_valid"}, 80'(seen), 80'd1);
    check({tag, " latency"}, 80'(lat), 80'(e.lat));
    check({tag, " response"}, 80'(o_rsp), 80'(e.rsp));
    check({tag, " compressed_out"}, 80'(o_cidx), 80'(e.cidx));
    check({tag, " decompressed_out"}, o_data, e.data);
    check({tag, " hit"}, 80'(o_hit), 80'(e.hit));
    check({tag, " fill_count"}, 80'(o_fill), 80'(e.fill));
    check({tag, " cmd_ready busy"}, 80'(o_cmd_ready), 80'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, " held rsp_valid"}, 80'(o_rsp_valid), 80'd1);
      check({tag, " held response"}, 80'(o_rsp), 80'(e.rsp));
      check({tag, " held decompressed_out"}, o_data, e.data);
      check({tag, " held compressed_out"}, 80'(o_cidx), 80'(e.cidx));
      check({tag, " held cmd_ready"}, 80'(o_cmd_ready), 80'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, " rsp_valid drop"}, 80'(o_rsp_valid), 80'd0);
    check({tag, " cmd_ready back"}, 80'(o_cmd_ready), 80'd1);
  endtask

  function automatic logic [79:0] word_of(input int i);
    return {16'hC0DE, 32'(i) * 32'd2654435761, 32'(i)};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "timeout");
  end

  initial begin
    sel       = 1'b0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    command   = CMD_CLEAR;
    data_in   = '0;
    cidx_in   = '0;
    model_reset(4, 1);

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset cmd_ready", 80'(o_cmd_ready), 80'd0);
    check("reset rsp_valid", 80'(o_rsp_valid), 80'd0);
    check("reset fill_count", 80'(o_fill), 80'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post-reset cmd_ready", 80'(o_cmd_ready), 80'd1);
    check("post-reset response", 80'(o_rsp), 80'd0);
    check("post-reset compressed_out", 80'(o_cidx), 80'd0);
    check("post-reset decompressed_out", o_data, 80'd0);
    check("post-reset hit", 80'(o_hit), 80'd0);

    // Zero is a legal word.
    run_cmd(CMD_COMPRESS, 80'h0, 0, 0, "zero insert");
    run_cmd(CMD_COMPRESS, 80'h0, 0, 0, "zero hit");
    run_cmd(CMD_CLEAR, 80'h0, 0, 0, "clear");

    // Fill to capacity, overflow, then hit.
    run_cmd(CMD_COMPRESS, 80'hA1, 0, 0, "insert A");
    run_cmd(CMD_COMPRESS, 80'hB2, 0, 0, "insert B");
    run_cmd(CMD_COMPRESS, 80'hC3, 0, 0, "insert C");
    run_cmd(CMD_COMPRESS, 80'hD4, 0, 0, "insert D");
    run_cmd(CMD_COMPRESS, 80'hE5, 0, 0, "full error");
    run_cmd(CMD_COMPRESS, 80'hC3, 0, 0, "hit C");

    // Decompress with a 5-cycle response stall, then out of range.
    run_cmd(CMD_DECOMPRESS, 80'h0, 3, 5, "decomp 3");
    run_cmd(CMD_DECOMPRESS, 80'h0, 4, 0, "decomp 4");

    // Reset while a search is in flight.
    @(negedge clk);
    command   = CMD_COMPRESS;
    data_in   = 80'hF00D;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("search in flight", 80'(o_rsp_valid), 80'd0);
    reset = 1'b1;
    @(negedge clk);
    check("mid reset cmd_ready", 80'(o_cmd_ready), 80'd0);
    reset = 1'b0;
    model_reset(4, 1);
    check("abort fill_count", 80'(o_fill), 80'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort no response", 80'(o_rsp_valid), 80'd0);
    end

    run_cmd(CMD_ILLEGAL, 80'h0, 0, 0, "illegal");
    run_cmd(CMD_COMPRESS, 80'h1234, 0, 0, "insert pre-clear");
    run_cmd(CMD_CLEAR, 80'h0, 0, 0, "clear again");

    // Large instance: multi-lane scan.
    sel = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset(255, 4);
    for (int i = 0; i < 200; i++)
      run_cmd(CMD_COMPRESS, word_of(i), 0, 0, "big fill");
    run_cmd(CMD_COMPRESS, word_of(199), 0, 0, "big hit 199");
    run_cmd(CMD_COMPRESS, word_of(1000), 0, 0, "big insert 200");
    run_cmd(CMD_DECOMPRESS, 80'h0, 137, 0, "big decomp 137");
    run_cmd(CMD_DECOMPRESS, 80'h0, 250, 0, "big decomp 250");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
